jscan_test_sequencer: RTL and testbench

Parametrised successor to the global test controller for the monolithic-3D JSCAN fabric. A start-triggered FSM sweeps every (mode, column, cluster, tier) combination. For each pattern it runs a SHIFT burst of programmable length, a single CAPTURE pulse and a MISR CHECK cycle. It accumulates a sticky per-tier fault vector and signals completion. It sits at the top of the test hierarchy and drives the tier/column/cluster decoders and the TSV scan-in feed.

---
 rtl/jscan_test_sequencer.sv | 161 ++++++++++++++++
 tb/tb_jscan_test_sequencer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/jscan_test_sequencer.sv
// rtl/jscan_test_sequencer.sv - JSCAN global test sequencer sweeping mode/column/cluster/tier patterns
module jscan_test_sequencer #(
  parameter int NUM_TIERS = 3,
  parameter int CLUSTERS  = 4,
  parameter int COL_W     = 4,
  parameter int SHIFT_LEN = 8,
  parameter int NUM_MODES = 3,
  localparam int CL_W     = $clog2(CLUSTERS)
) (
  input  logic                 scan_clk,
  input  logic                 reset_n,
  input  logic                 test_enable,
  input  logic                 start,
  input  logic                 scan_in,
  input  logic [NUM_TIERS-1:0] misr_fail,
  output logic                 test_en,
  output logic                 tsv_scan_in,
  output logic [1:0]           tier_sel,
  output logic [1:0]           mode_sel,
  output logic [COL_W-1:0]     col_addr,
  output logic [CL_W-1:0]      cluster_sel,
  output logic                 shift_en,
  output logic                 capture_en,
  output logic                 busy,
  output logic                 done,
  output logic [NUM_TIERS-1:0] fault_tier,
  output logic                 fault_flag
);

  localparam int         SH_W     = (SHIFT_LEN > 1) ? $clog2(SHIFT_LEN) : 1;
  localparam logic [1:0] TIER_MAX = 2'(NUM_TIERS);
  localparam logic [1:0] MODE_MAX = 2'(NUM_MODES - 1);
  localparam logic [SH_W-1:0] SH_LAST = SH_W'(SHIFT_LEN - 1);

  typedef enum logic [2:0] {S_IDLE, S_SHIFT, S_CAPTURE, S_CHECK, S_DONE} state_e;

  state_e                 state_q, state_d;
  logic [1:0]             tier_q, tier_d, mode_q, mode_d;
  logic [COL_W-1:0]       col_q, col_d;
  logic [CL_W-1:0]        cl_q, cl_d;
  logic [SH_W-1:0]        cnt_q, cnt_d;
  logic [NUM_TIERS-1:0]   fault_q, fault_d;
  logic                   flag_q, flag_d;
  logic                   last_pat;

  always_ff @(posedge scan_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      tier_q  <= 2'd1;
      mode_q  <= 2'd0;
      col_q   <= '0;
      cl_q    <= '0;
      cnt_q   <= '0;
      fault_q <= '0;
      flag_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tier_q  <= tier_d;
      mode_q  <= mode_d;
      col_q   <= col_d;
      cl_q    <= cl_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
      flag_q  <= flag_d;
    end
  end

  assign last_pat = (tier_q == TIER_MAX) && (cl_q == {CL_W{1'b1}}) &&
                    (col_q == {COL_W{1'b1}}) && (mode_q == MODE_MAX);

  always_comb begin
    state_d = state_q;
    tier_d  = tier_q;
    mode_d  = mode_q;
    col_d   = col_q;
    cl_d    = cl_q;
    cnt_d   = cnt_q;
    fault_d = fault_q;
    if (!test_enable) begin
      // Abort: drop back to IDLE with reset indices but keep the logged faults
      state_d = S_IDLE;
      tier_d  = 2'd1;
      mode_d  = 2'd0;
      col_d   = '0;
      cl_d    = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d = S_SHIFT;
            fault_d = '0;
            tier_d  = 2'd1;
            mode_d  = 2'd0;
            col_d   = '0;
            cl_d    = '0;
            cnt_d   = '0;
          end
        end
        S_SHIFT: begin
          if (cnt_q == SH_LAST) begin
            cnt_d   = '0;
            state_d = S_CAPTURE;
          end else begin
            cnt_d = cnt_q + SH_W'(1);
          end
        end
        S_CAPTURE: state_d = S_CHECK;
        S_CHECK: begin
          fault_d = fault_q | misr_fail;
          if (last_pat) begin
            state_d = S_DONE;
            tier_d  = 2'd1;
            mode_d  = 2'd0;
            col_d   = '0;
            cl_d    = '0;
          end else begin
            // Tier is the innermost index; each wrap carries outward
            state_d = S_SHIFT;
            if (tier_q != TIER_MAX) begin
              tier_d = tier_q + 2'd1;
            end else begin
              tier_d = 2'd1;
              if (cl_q != {CL_W{1'b1}}) begin
                cl_d = cl_q + CL_W'(1);
              end else begin
                cl_d = '0;
                if (col_q != {COL_W{1'b1}}) begin
                  col_d = col_q + COL_W'(1);
                end else begin
                  col_d  = '0;
                  mode_d = (mode_q == MODE_MAX) ? 2'd0 : mode_q + 2'd1;
                end
              end
            end
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
    flag_d = |fault_d;
  end

  always_comb begin
    shift_en   = (state_q == S_SHIFT);
    capture_en = (state_q == S_CAPTURE);
    busy       = (state_q == S_SHIFT) || (state_q == S_CAPTURE) || (state_q == S_CHECK);
    done       = (state_q == S_DONE);
  end

  assign test_en     = test_enable;
  assign tsv_scan_in = scan_in;
  assign tier_sel    = tier_q;
  assign mode_sel    = mode_q;
  assign col_addr    = col_q;
  assign cluster_sel = cl_q;
  assign fault_tier  = fault_q;
  assign fault_flag  = flag_q;

endmodule

// File: tb/tb_jscan_test_sequencer.sv
// tb/tb_jscan_test_sequencer.sv - self-checking bench for jscan_test_sequencer
module tb_jscan_test_sequencer;

  localparam int NT    = 3;
  localparam int CL    = 2;
  localparam int COLW  = 1;
  localparam int SL    = 4;
  localparam int NM    = 2;
  localparam int CLW   = $clog2(CL);
  localparam int NPAT  = NT * CL * (1 << COLW) * NM;
  localparam int TOTAL_BUSY = NPAT * (SL + 2);

  logic            clk;
  logic            reset_n, test_enable, start, scan_in;
  logic [NT-1:0]   misr_fail;
  logic            test_en, tsv_scan_in;
  logic [1:0]      tier_sel, mode_sel;
  logic [COLW-1:0] col_addr;
  logic [CLW-1:0]  cluster_sel;
  logic            shift_en, capture_en, busy, done;
  logic [NT-1:0]   fault_tier;
  logic            fault_flag;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int busy_cnt, done_cnt, cap_cnt, shift_cnt, cap1_cyc, s0;
  logic inj;
  logic [31:0] sb[$];

  typedef struct {
    logic te;
    logic si;
    logic st;
    logic e_ten;
    logic e_tsv;
  } vec_t;
  vec_t vecs[6];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  jscan_test_sequencer #(
    .NUM_TIERS(NT), .CLUSTERS(CL), .COL_W(COLW), .SHIFT_LEN(SL), .NUM_MODES(NM)
  ) dut (
    .scan_clk(clk), .reset_n(reset_n), .test_enable(test_enable), .start(start),
    .scan_in(scan_in), .misr_fail(misr_fail), .test_en(test_en), .tsv_scan_in(tsv_scan_in),
    .tier_sel(tier_sel), .mode_sel(mode_sel), .col_addr(col_addr), .cluster_sel(cluster_sel),
    .shift_en(shift_en), .capture_en(capture_en), .busy(busy), .done(done),
    .fault_tier(fault_tier), .fault_flag(fault_flag)
  );

  function automatic logic [31:0] pack(input int m, input int c, input int k, input int t);
    return 32'((m << (COLW + CLW + 2)) | (c << (CLW + 2)) | (k << 2) | t);
  endfunction

  function automatic logic [31:0] dut_idx();
    return 32'({mode_sel, col_addr, cluster_sel, tier_sel});
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    logic [31:0] e;
    @(posedge clk);
    #1;
    cyc++;
    if (busy) busy_cnt++;
    if (done) done_cnt++;
    if (shift_en) shift_cnt++;
    if (capture_en) begin
      cap_cnt++;
      if (cap_cnt == 1) cap1_cyc = cyc;
      if (sb.size() == 0) begin
        chk("capture_unexpected", dut_idx(), 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        chk("capture_idx", dut_idx(), e);
      end
    end
  endtask

  task automatic load_sb();
    sb.delete();
    for (int m = 0; m < NM; m++)
      for (int c = 0; c < (1 << COLW); c++)
        for (int k = 0; k < CL; k++)
          for (int t = 1; t <= NT; t++)
            sb.push_back(pack(m, c, k, t));
    busy_cnt = 0; done_cnt = 0; cap_cnt = 0; shift_cnt = 0; cap1_cyc = 0;
  endtask

  initial begin
    vecs[0] = '{te: 1'b0, si: 1'b0, st: 1'b0, e_ten: 1'b0, e_tsv: 1'b0};
    vecs[1] = '{te: 1'b0, si: 1'b1, st: 1'b0, e_ten: 1'b0, e_tsv: 1'b1};
    vecs[2] = '{te: 1'b1, si: 1'b0, st: 1'b0, e_ten: 1'b1, e_tsv: 1'b0};
    vecs[3] = '{te: 1'b1, si: 1'b1, st: 1'b0, e_ten: 1'b1, e_tsv: 1'b1};
    vecs[4] = '{te: 1'b0, si: 1'b1, st: 1'b1, e_ten: 1'b0, e_tsv: 1'b1};
    vecs[5] = '{te: 1'b0, si: 1'b0, st: 1'b1, e_ten: 1'b0, e_tsv: 1'b0};

    reset_n = 1'b0; test_enable = 1'b0; start = 1'b0; scan_in = 1'b0; misr_fail = '0;
    busy_cnt = 0; done_cnt = 0; cap_cnt = 0; shift_cnt = 0; cap1_cyc = 0; s0 = 0; inj = 1'b0;
    #2;
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    chk("rst_idx", dut_idx(), pack(0, 0, 0, 1));
    chk("rst_shift", 32'(shift_en), 0);
    chk("rst_capture", 32'(capture_en), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_fault", 32'(fault_tier), 0);
    chk("rst_flag", 32'(fault_flag), 0);

    // Pass-through paths and start ignored while test_enable is low
    for (int i = 0; i < 6; i++) begin
      test_enable = vecs[i].te; scan_in = vecs[i].si; start = vecs[i].st;
      #1;
      chk("vec_test_en", 32'(test_en), 32'(vecs[i].e_ten));
      chk("vec_tsv_scan_in", 32'(tsv_scan_in), 32'(vecs[i].e_tsv));
      step();
      chk("vec_idle_busy", 32'(busy), 0);
      chk("vec_idle_shift", 32'(shift_en), 0);
    end

    // Full sweep with fault injection and a start pulse while busy
    test_enable = 1'b1; scan_in = 1'b0; start = 1'b1;
    load_sb();
    step();
    start = 1'b0;
    s0 = cyc;
    chk("shift_after_start", 32'(shift_en), 1);
    for (int i = 0; i < 1000 && done_cnt == 0; i++) begin
      misr_fail = '0;
      if (busy && !shift_en && !capture_en && cap_cnt == 5) misr_fail = 3'b010;
      if (capture_en && cap_cnt == 3) misr_fail = 3'b101;
      start = capture_en && (cap_cnt == 2);
      if (capture_en && cap_cnt == 5) chk("fault_before_p5", 32'(fault_tier), 0);
      inj = (misr_fail == 3'b010);
      step();
      if (inj) begin
        chk("fault_after_p5", 32'(fault_tier), 32'b010);
        chk("flag_after_p5", 32'(fault_flag), 1);
      end
    end
    misr_fail = '0; start = 1'b0;
    chk("done_seen", 32'(done_cnt), 1);
    chk("done_idx_reset", dut_idx(), pack(0, 0, 0, 1));
    chk("done_not_busy", 32'(busy), 0);
    chk("busy_cycles", 32'(busy_cnt), 32'(TOTAL_BUSY));
    chk("capture_count", 32'(cap_cnt), 32'(NPAT));
    chk("shift_count", 32'(shift_cnt), 32'(NPAT * SL));
    chk("sb_empty", 32'(sb.size()), 0);
    chk("capture_latency", 32'(cap1_cyc - s0), 32'(SL));
    step();
    chk("done_one_cycle", 32'(done), 0);
    chk("idle_after_done", 32'(busy), 0);
    chk("fault_hold_idle", 32'(fault_tier), 32'b010);
    chk("flag_hold_idle", 32'(fault_flag), 1);

    // New start clears faults; abort in the 3rd SHIFT cycle of pattern 2
    load_sb();
    start = 1'b1;
    step();
    start = 1'b0;
    chk("fault_cleared_on_start", 32'(fault_tier), 0);
    chk("flag_cleared_on_start", 32'(fault_flag), 0);
    for (int i = 0; i < 100 && shift_cnt < SL + 3; i++) begin
      misr_fail = (busy && !shift_en && !capture_en && cap_cnt == 1) ? 3'b001 : 3'b000;
      step();
    end
    misr_fail = '0;
    chk("abort_point", 32'(shift_cnt), 32'(SL + 3));
    test_enable = 1'b0;
    step();
    chk("abort_busy", 32'(busy), 0);
    chk("abort_shift", 32'(shift_en), 0);
    chk("abort_idx", dut_idx(), pack(0, 0, 0, 1));
    chk("abort_no_done", 32'(done), 0);
    chk("abort_fault_hold", 32'(fault_tier), 32'b001);
    chk("abort_flag_hold", 32'(fault_flag), 1);
    step();
    chk("abort_no_done_later", 32'(done_cnt), 0);

    // Asynchronous reset mid-CAPTURE after a fault was logged
    test_enable = 1'b1;
    load_sb();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 100 && !(capture_en && cap_cnt == 2); i++) begin
      misr_fail = (busy && !shift_en && !capture_en && cap_cnt == 1) ? 3'b100 : 3'b000;
      step();
    end
    misr_fail = '0;
    chk("pre_reset_capture", 32'(capture_en), 1);
    chk("pre_reset_fault", 32'(fault_tier), 32'b100);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_capture", 32'(capture_en), 0);
    chk("async_rst_busy", 32'(busy), 0);
    chk("async_rst_idx", dut_idx(), pack(0, 0, 0, 1));
    chk("async_rst_fault", 32'(fault_tier), 0);
    chk("async_rst_flag", 32'(fault_flag), 0);
    #3 reset_n = 1'b1;
    sb.delete();
    step();
    chk("post_reset_idle", 32'(busy), 0);
    chk("post_reset_done", 32'(done), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
